// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: controller state encoding and the
// per-stage {en, flush} control pair with its three common values.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t STG_HOLD   = '{en: 1'b0, flush: 1'b0};
   localparam stage_ctrl_t STG_ADV    = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t STG_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage enable/flush sequencer: resolves memory waits, branches, load-use
// stalls, jumps and fetch misses into latch controls, and drains on halt.
module pipeline_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       StallLW,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             EXMEM_dREN,
   input  logic             EXMEM_dWEN,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             MEMWB_halt,
   output logic             PC_en,
   output logic             IFID_en,
   output logic             IDEX_en,
   output logic             EXMEM_en,
   output logic             MEMWB_en,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             EXMEM_flush,
   output logic             MEMWB_flush,
   output logic             halt,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipeline_ctrl_pkg::*;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   ctrl_state_t state_q, state_d;
   logic [3:0]  drain_q, drain_d;
   logic        halt_q, halt_d;

   stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;
   logic        pc_en;
   logic        data_wait;
   logic        active;

   assign data_wait = (EXMEM_dREN | EXMEM_dWEN) & ~dhit;
   assign active    = (state_q == RUN) || (state_q == DWAIT);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      pc_en   = 1'b0;
      ifid_c  = STG_HOLD;
      idex_c  = STG_HOLD;
      exmem_c = STG_HOLD;
      memwb_c = STG_HOLD;

      // Priority chain; reset forces every stage to hold with no bubble.
      if (!RST && active) begin
         if (data_wait) begin
            memwb_c = STG_BUBBLE;
         end else if (branch_taken) begin
            pc_en   = 1'b1;
            ifid_c  = STG_BUBBLE;
            idex_c  = STG_BUBBLE;
            exmem_c = STG_ADV;
            memwb_c = STG_ADV;
         end else if (StallLW != 2'b00) begin
            idex_c  = STG_BUBBLE;
            exmem_c = STG_ADV;
            memwb_c = STG_ADV;
         end else if (jump) begin
            pc_en   = ihit;
            ifid_c  = STG_BUBBLE;
            idex_c  = STG_ADV;
            exmem_c = STG_ADV;
            memwb_c = STG_ADV;
         end else if (!ihit) begin
            ifid_c  = STG_BUBBLE;
            idex_c  = STG_ADV;
            exmem_c = STG_ADV;
            memwb_c = STG_ADV;
         end else begin
            pc_en   = 1'b1;
            ifid_c  = STG_ADV;
            idex_c  = STG_ADV;
            exmem_c = STG_ADV;
            memwb_c = STG_ADV;
         end
      end

      case (state_q)
         RUN: begin
            if (MEMWB_halt) begin
               state_d = DRAIN;
               drain_d = DRAIN_LOAD;
            end else if (data_wait) begin
               state_d = DWAIT;
            end
         end
         DWAIT: begin
            if (dhit) state_d = RUN;
         end
         DRAIN: begin
            if (drain_q == 4'd0) state_d = HALTED;
            else                 drain_d = drain_q - 4'd1;
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: state_d = RUN;
      endcase
   end

   assign halt_d = (state_d == HALTED);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         drain_q <= 4'd0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         halt_q  <= halt_d;
      end
   end

   assign PC_en       = pc_en;
   assign IFID_en     = ifid_c.en;
   assign IDEX_en     = idex_c.en;
   assign EXMEM_en    = exmem_c.en;
   assign MEMWB_en    = memwb_c.en;
   assign IFID_flush  = ifid_c.flush  & ifid_c.en;
   assign IDEX_flush  = idex_c.flush  & idex_c.en;
   assign EXMEM_flush = exmem_c.flush & exmem_c.en;
   assign MEMWB_flush = memwb_c.flush & memwb_c.en;
   assign halt        = halt_q;

   sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk   (CLK),
      .clr   (RST),
      .inc   (state_q != HALTED),
      .count (cyc_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (CLK),
      .clr   (RST),
      .inc   (active && !pc_en),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (CLK),
      .clr   (RST),
      .inc   (IFID_flush | IDEX_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed control vectors, counter
// values and halt timing, plus a narrow-counter instance for saturation.
module tb_pipeline_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  StallLW;
   logic        ihit, dhit, EXMEM_dREN, EXMEM_dWEN;
   logic        branch_taken, jump, MEMWB_halt;

   logic        PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
   logic        IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush;
   logic        halt;
   logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

   logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic        s_ifid_fl, s_idex_fl, s_exmem_fl, s_memwb_fl;
   logic        s_halt;
   logic [3:0]  s_cyc_cnt, s_stall_cnt, s_flush_cnt;

   int errors = 0;
   int checks = 0;

   // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, EXMEM_flush, MEMWB_en, MEMWB_flush}
   logic [8:0] ctl;
   assign ctl = {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush,
                 EXMEM_en, EXMEM_flush, MEMWB_en, MEMWB_flush};

   localparam logic [8:0] V_NONE    = 9'b0_00_00_00_00;
   localparam logic [8:0] V_ADV     = 9'b1_10_10_10_10;
   localparam logic [8:0] V_DWAIT   = 9'b0_00_00_00_11;
   localparam logic [8:0] V_BRANCH  = 9'b1_11_11_10_10;
   localparam logic [8:0] V_LOADUSE = 9'b0_00_11_10_10;
   localparam logic [8:0] V_NOFETCH = 9'b0_11_10_10_10;
   localparam logic [8:0] V_JUMP_OK = 9'b1_11_10_10_10;

   pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .StallLW(StallLW), .ihit(ihit), .dhit(dhit),
      .EXMEM_dREN(EXMEM_dREN), .EXMEM_dWEN(EXMEM_dWEN),
      .branch_taken(branch_taken), .jump(jump), .MEMWB_halt(MEMWB_halt),
      .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
      .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
      .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
      .EXMEM_flush(EXMEM_flush), .MEMWB_flush(MEMWB_flush),
      .halt(halt), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(RST), .StallLW(StallLW), .ihit(ihit), .dhit(dhit),
      .EXMEM_dREN(EXMEM_dREN), .EXMEM_dWEN(EXMEM_dWEN),
      .branch_taken(branch_taken), .jump(jump), .MEMWB_halt(MEMWB_halt),
      .PC_en(s_pc_en), .IFID_en(s_ifid_en), .IDEX_en(s_idex_en),
      .EXMEM_en(s_exmem_en), .MEMWB_en(s_memwb_en),
      .IFID_flush(s_ifid_fl), .IDEX_flush(s_idex_fl),
      .EXMEM_flush(s_exmem_fl), .MEMWB_flush(s_memwb_fl),
      .halt(s_halt), .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      StallLW = 2'b00; ihit = 1'b1; dhit = 1'b0;
      EXMEM_dREN = 1'b0; EXMEM_dWEN = 1'b0;
      branch_taken = 1'b0; jump = 1'b0; MEMWB_halt = 1'b0;
   endtask

   // Advance one edge, then settle so registered outputs are stable.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int c, input int s, input int f);
      chk({tag, "_cyc"},   cyc_cnt,   32'(c));
      chk({tag, "_stall"}, stall_cnt, 32'(s));
      chk({tag, "_flush"}, flush_cnt, 32'(f));
   endtask

   initial begin
      // Reset
      idle();
      RST = 1'b1;
      #1;
      chk("rst_ctl", 32'(ctl), 32'(V_NONE));
      tick();
      tick();
      chk("rst_halt", 32'(halt), 32'd0);
      chk_cnt("rst", 0, 0, 0);
      RST = 1'b0;

      // Plain advance
      #1 chk("idle_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      chk_cnt("idle", 1, 0, 0);

      // Load-use stall
      StallLW = 2'b01;
      #1 chk("lu_ctl", 32'(ctl), 32'(V_LOADUSE));
      tick();
      chk_cnt("lu", 2, 1, 1);

      // Data wait for three cycles; halt in MEMWB ignored while waiting
      idle(); EXMEM_dREN = 1'b1;
      #1 chk("dw1_ctl", 32'(ctl), 32'(V_DWAIT));
      tick();
      MEMWB_halt = 1'b1;
      #1 chk("dw2_ctl", 32'(ctl), 32'(V_DWAIT));
      tick();
      #1 chk("dw3_ctl", 32'(ctl), 32'(V_DWAIT));
      tick();
      dhit = 1'b1;
      #1 chk("dhit_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      chk_cnt("dw", 6, 4, 1);
      idle();
      #1 chk("post_dw_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      chk_cnt("post_dw", 7, 4, 1);

      // Branch overrides load-use
      branch_taken = 1'b1; StallLW = 2'b01;
      #1 chk("br_lu_ctl", 32'(ctl), 32'(V_BRANCH));
      tick();
      chk_cnt("br_lu", 8, 4, 2);

      // Jump while fetch outstanding, then fetch completes
      idle(); jump = 1'b1; ihit = 1'b0;
      #1 chk("jmp_miss_ctl", 32'(ctl), 32'(V_NOFETCH));
      tick();
      ihit = 1'b1;
      #1 chk("jmp_hit_ctl", 32'(ctl), 32'(V_JUMP_OK));
      tick();
      chk_cnt("jmp", 10, 5, 4);

      // dhit together with a fetch miss
      idle(); EXMEM_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0;
      #1 chk("dhit_miss_ctl", 32'(ctl), 32'(V_NOFETCH));
      tick();

      // Branch beats jump; data wait beats branch (store side)
      idle(); branch_taken = 1'b1; jump = 1'b1;
      #1 chk("br_jmp_ctl", 32'(ctl), 32'(V_BRANCH));
      tick();
      idle(); EXMEM_dWEN = 1'b1; branch_taken = 1'b1; StallLW = 2'b10;
      #1 chk("dw_br_ctl", 32'(ctl), 32'(V_DWAIT));
      tick();
      idle(); EXMEM_dWEN = 1'b1; dhit = 1'b1;
      #1 chk("dw_exit_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      chk_cnt("prio", 14, 7, 6);

      // Halt drain with DRAIN_CYCLES=2
      idle(); MEMWB_halt = 1'b1;
      #1 chk("halt_in_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      MEMWB_halt = 1'b0;
      #1 chk("drain1_ctl", 32'(ctl), 32'(V_NONE));
      chk("drain1_halt", 32'(halt), 32'd0);
      tick();
      #1 chk("drain2_ctl", 32'(ctl), 32'(V_NONE));
      chk("drain2_halt", 32'(halt), 32'd0);
      tick();
      chk("halted_halt", 32'(halt), 32'd1);
      chk_cnt("halted", 17, 7, 6);
      branch_taken = 1'b1;
      #1 chk("halted_ctl", 32'(ctl), 32'(V_NONE));
      tick();
      tick();
      chk_cnt("halted_frozen", 17, 7, 6);
      chk("halted_hold", 32'(halt), 32'd1);

      // Reset out of HALTED
      idle(); RST = 1'b1;
      #1 chk("rst_halted_ctl", 32'(ctl), 32'(V_NONE));
      tick();
      chk("rst_halted_halt", 32'(halt), 32'd0);
      chk_cnt("rst_halted", 0, 0, 0);
      RST = 1'b0;

      // Reset mid-DWAIT, then prove RUN by accepting a halt
      EXMEM_dREN = 1'b1;
      tick();
      chk_cnt("dw_pre_rst", 1, 1, 0);
      RST = 1'b1;
      #1 chk("rst_dw_ctl", 32'(ctl), 32'(V_NONE));
      tick();
      chk_cnt("rst_dw", 0, 0, 0);
      RST = 1'b0;
      idle(); MEMWB_halt = 1'b1;
      #1 chk("rst_dw_run_ctl", 32'(ctl), 32'(V_ADV));
      tick();
      MEMWB_halt = 1'b0;
      #1 chk("rst_dw_drain_ctl", 32'(ctl), 32'(V_NONE));
      chk_cnt("rst_dw_run", 1, 0, 0);

      // Saturation: 20 load-use cycles
      RST = 1'b1;
      tick();
      RST = 1'b0;
      StallLW = 2'b01;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall_narrow", 32'(s_stall_cnt), 32'd15);
      chk("sat_cyc_narrow",   32'(s_cyc_cnt),   32'd15);
      chk("sat_flush_narrow", 32'(s_flush_cnt), 32'd15);
      chk("sat_stall_wide",   stall_cnt,        32'd20);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Per-stage enable/flush sequencer for the five-stage pipeline. It consumes the hazard unit's stall request plus the memory-handshake and control-flow events, and drives the hold and bubble controls of PC, IFID, IDEX, EXMEM and MEMWB. It also sequences halt drain and keeps stall/flush performance counters. It sits beside the hazard unit in the datapath top level and is the only source of latch enables and flushes.

## Interface
Parameters:
- DRAIN_CYCLES, 2: cycles between halt reaching MEMWB and `halt` asserting; range 1..15.
- CNT_W, 32: performance-counter width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- StallLW  in  2  load-use stall request from hazard unit; nonzero = stall.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- EXMEM_dREN, EXMEM_dWEN  in  1 each  data access pending in MEM.
- branch_taken  in  1  branch/jr resolved taken in EX; PC loads target.
- jump  in  1  j/jal decoded in ID; PC loads target.
- MEMWB_halt  in  1  halt instruction in MEMWB.
- PC_en  out  1  PC register load enable.
- IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  latch enables.
- IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush  out  1 each  load a bubble when the matching enable is also high.
- halt  out  1  registered; processor halted.
- cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  registered performance counters.

## Operation
- FSM states: RUN, DWAIT, DRAIN, HALTED. Encoding lives in the shared package.
- RUN:
  - Go to DWAIT if (EXMEM_dREN|EXMEM_dWEN)&!dhit.
  - Go to DRAIN if MEMWB_halt. Load drain counter with DRAIN_CYCLES-1.
  - MEMWB_halt has priority over the DWAIT transition.
- DWAIT: return to RUN on dhit. MEMWB_halt is ignored in this state.
- DRAIN:
  - All enables 0.
  - Counter decrements each cycle. At 0, go to HALTED.
- HALTED: all enables 0. Only RST exits.
- Control priority in RUN/DWAIT, highest first. Each cycle exactly one rule applies.
  1. Data wait ((dREN|dWEN)&!dhit): PC, IFID, IDEX, EXMEM held (en=0). MEMWB_en=1, MEMWB_flush=1.
  2. branch_taken: PC_en=1. IFID_en=IDEX_en=1 with IFID_flush=IDEX_flush=1. EXMEM/MEMWB advance. Overrides StallLW and jump.
  3. StallLW!=0: PC_en=0, IFID_en=0. IDEX_en=1, IDEX_flush=1. EXMEM/MEMWB advance.
  4. jump: PC_en=ihit. IFID_en=1, IFID_flush=1. Rest advance.
  5. !ihit: PC_en=0. IFID_en=1, IFID_flush=1. Rest advance.
  6. Otherwise: all enables 1, all flushes 0.
- Flushes are 0 whenever the matching enable is 0.
- Counters:
  - cyc_cnt increments every cycle while not HALTED.
  - stall_cnt increments on any cycle with PC_en=0 outside DRAIN/HALTED.
  - flush_cnt increments once per cycle in which any of IFID_flush or IDEX_flush is asserted.
  - All counters saturate at all-ones; they never wrap.

## Timing
- Enables and flushes are combinational (Mealy) from state and inputs, valid the same cycle.
- halt and all counters are registered.
- Reset values: state RUN, halt 0, all counters 0, drain counter 0.
- Combinational outputs during RST=1 must be: all enables 0, all flushes 0.
- Halt latency:
  - MEMWB_halt sampled at edge N moves state to DRAIN.
  - State reaches HALTED at edge N+DRAIN_CYCLES.
  - halt=1 from the cycle after that edge.
- DWAIT exit: in the cycle dhit=1, rule 1 no longer applies and the pipeline advances. State becomes RUN at the next edge.
- Simultaneous dhit and !ihit: rule 5 applies.
- RST asserted in DRAIN/HALTED/DWAIT returns to RUN next edge and clears halt.

## Structure
- Shared package holds the `ctrl_state_t` enum (RUN, DWAIT, DRAIN, HALTED) and the `stage_ctrl_t` packed struct {en, flush}. Use this struct for outputs internally.
- One sub-module: `sat_counter` (parameter CNT_W, inputs inc/clr). Instantiate it three times.
- Drain counter is 4 bits, inline.

## Test plan
- Load-use: StallLW=2'b01, ihit=1 for 1 cycle → PC_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=1. stall_cnt 0→1.
- Data wait: dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with PC/IFID/IDEX/EXMEM_en=0 and MEMWB_flush=1. Normal advance in the dhit cycle. stall_cnt=3.
- Branch during load-use: branch_taken=1, StallLW=2'b01 → PC_en=1, IFID_flush=IDEX_flush=1. flush_cnt +1, stall_cnt unchanged.
- Jump with !ihit: jump=1, ihit=0 → PC_en=0, IFID_flush=1. Next cycle ihit=1 → PC_en=1.
- Halt: MEMWB_halt at edge 10, DRAIN_CYCLES=2 → enables 0 from edge 10, halt=1 after edge 12. cyc_cnt frozen at its value at edge 12.
- Reset mid-DWAIT, plus saturation:
  - RST during DWAIT → RUN, counters 0 next cycle.
  - With CNT_W=4 and 20 stall cycles → stall_cnt=15.
